// File: rtl/tetris_pkg.sv
// Shared tetromino definitions: shape codes, widths, bag constants,
// spawn defaults, queue entry type and pop-FSM state encoding.
package tetris_pkg;

  localparam int SHAPE_W = 3;
  localparam int ROT_W   = 2;

  localparam logic [SHAPE_W-1:0] SHAPE_I = 3'd0;
  localparam logic [SHAPE_W-1:0] SHAPE_O = 3'd1;
  localparam logic [SHAPE_W-1:0] SHAPE_T = 3'd2;
  localparam logic [SHAPE_W-1:0] SHAPE_S = 3'd3;
  localparam logic [SHAPE_W-1:0] SHAPE_Z = 3'd4;
  localparam logic [SHAPE_W-1:0] SHAPE_J = 3'd5;
  localparam logic [SHAPE_W-1:0] SHAPE_L = 3'd6;

  localparam logic [6:0] BAG_FULL = 7'h7F;

  localparam int DEF_SPAWN_X = 8;
  localparam int DEF_SPAWN_Y = 0;

  typedef struct packed {
    logic [SHAPE_W-1:0] shape;
    logic [ROT_W-1:0]   rot;
  } piece_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } pop_state_t;

  function automatic logic [SHAPE_W-1:0] lowest_set(
    input logic [6:0] m
  );
    lowest_set = '0;
    for (int i = 6; i >= 0; i--)
      if (m[i]) lowest_set = SHAPE_W'(i);
  endfunction

endpackage

// File: rtl/piece_fifo.sv
// Synchronous FIFO of piece entries with push/pop/flush.
// Ports: clk, rst, flush, push, pop, din, dout (head), count.
module piece_fifo
  import tetris_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  piece_t        din,
  output piece_t        dout,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  piece_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/piece_scheduler.sv
// 7-bag tetromino scheduler with preview queue and spawn handshake.
// Ports: i_clk, i_rst, i_rnd, i_req, i_flush -> o_spawn_*, o_next_*, o_count.
module piece_scheduler
  import tetris_pkg::*;
#(
  parameter int QDEPTH    = 4,
  parameter int SPAWN_X   = DEF_SPAWN_X,
  parameter int SPAWN_Y   = DEF_SPAWN_Y,
  parameter int MAX_TRIES = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [7:0]   i_rnd,
  input  logic         i_req,
  input  logic         i_flush,
  output logic         o_spawn_valid,
  output logic [2:0]   o_shape,
  output logic [1:0]   o_rot,
  output logic [4:0]   o_x,
  output logic [4:0]   o_y,
  output logic [2:0]   o_next_shape,
  output logic         o_next_valid,
  output logic [2:0]   o_count
);

  localparam int CW = $clog2(QDEPTH + 1);
  localparam int TW = $clog2(MAX_TRIES + 1);

  logic [6:0]    bag_mask;
  logic [TW-1:0] tries;
  pop_state_t    state;

  logic [CW-1:0] cnt;
  piece_t        head;
  piece_t        push_piece;
  logic [2:0]    cand;
  logic [7:0]    mask_ext;
  logic [2:0]    pick;
  logic [6:0]    cleared;
  logic          fill_en;
  logic          hit;
  logic          force_pick;
  logic          push;
  logic          want;
  logic          pop;

  wire unused_rnd = ^i_rnd[7:5];

  // Bit 7 of the extended mask is 0, so candidate 7 always rejects.
  always_comb begin
    cand       = i_rnd[2:0];
    mask_ext   = {1'b0, bag_mask};
    fill_en    = !i_flush && (cnt < CW'(QDEPTH));
    hit        = mask_ext[cand];
    force_pick = (tries == TW'(MAX_TRIES - 1));
    push       = fill_en && (hit || force_pick);
    pick       = hit ? cand : lowest_set(bag_mask);
    push_piece = '{shape: pick, rot: i_rnd[4:3]};
    cleared    = bag_mask & ~(7'b1 << pick);
    want       = (state == ST_IDLE) ? i_req : 1'b1;
    pop        = !i_flush && want && (cnt != '0);
  end

  piece_fifo #(
    .DEPTH (QDEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .flush (i_flush),
    .push  (push),
    .pop   (pop),
    .din   (push_piece),
    .dout  (head),
    .count (cnt)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bag_mask      <= BAG_FULL;
      tries         <= '0;
      state         <= ST_IDLE;
      o_spawn_valid <= 1'b0;
      o_shape       <= '0;
      o_rot         <= '0;
      o_x           <= 5'(SPAWN_X);
      o_y           <= 5'(SPAWN_Y);
    end else if (i_flush) begin
      bag_mask      <= BAG_FULL;
      tries         <= '0;
      state         <= ST_IDLE;
      o_spawn_valid <= 1'b0;
    end else begin
      // Last piece of a bag reloads the mask on the same edge.
      if (push) begin
        tries    <= '0;
        bag_mask <= (cleared == '0) ? BAG_FULL : cleared;
      end else if (fill_en) begin
        tries <= tries + 1'b1;
      end
      o_spawn_valid <= pop;
      if (pop) begin
        o_shape <= head.shape;
        o_rot   <= head.rot;
        o_x     <= 5'(SPAWN_X);
        o_y     <= 5'(SPAWN_Y);
      end
      unique case (state)
        ST_IDLE: if (i_req && cnt == '0) state <= ST_WAIT;
        ST_WAIT: if (pop) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_count      = 3'(cnt);
  assign o_next_valid = (cnt != '0);
  assign o_next_shape = o_next_valid ? head.shape : 3'd0;

endmodule

// File: tb/tb_piece_scheduler.sv
// Directed self-checking bench for piece_scheduler.
// Drives i_rnd/i_req/i_flush; checks spawn, preview, count and bag state.
module tb_piece_scheduler;
  import tetris_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rnd;
  logic       req;
  logic       flush;
  logic       spawn_valid;
  logic [2:0] shape;
  logic [1:0] rot;
  logic [4:0] x;
  logic [4:0] y;
  logic [2:0] next_shape;
  logic       next_valid;
  logic [2:0] count;

  int tests = 0;
  int fails = 0;

  piece_scheduler dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_rnd         (rnd),
    .i_req         (req),
    .i_flush       (flush),
    .o_spawn_valid (spawn_valid),
    .o_shape       (shape),
    .o_rot         (rot),
    .o_x           (x),
    .o_y           (y),
    .o_next_shape  (next_shape),
    .o_next_valid  (next_valid),
    .o_count       (count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [7:0] lfsr;
  logic [2:0] got [14];
  logic [7:0] seen_a;
  logic [7:0] seen_b;
  int         n;

  initial begin
    rst = 1'b1; rnd = 8'hFF; req = 1'b0; flush = 1'b0;
    step(); step();

    // Reset state
    chk("rst_count", 32'(count), 0);
    chk("rst_nvalid", 32'(next_valid), 0);
    chk("rst_nshape", 32'(next_shape), 0);
    chk("rst_spawn", 32'(spawn_valid), 0);
    chk("rst_shape", 32'(shape), 0);
    chk("rst_rot", 32'(rot), 0);
    chk("rst_x", 32'(x), 8);
    chk("rst_y", 32'(y), 0);
    chk("rst_mask", 32'(dut.bag_mask), 32'h7F);
    chk("rst_tries", 32'(dut.tries), 0);
    chk("rst_state", 32'(dut.state), 32'(ST_IDLE));

    // Fill with shapes 0..3
    rst = 1'b0;
    rnd = 8'h00; step();
    rnd = 8'h01; step();
    rnd = 8'h02; step();
    rnd = 8'h03; step();
    chk("fill_count", 32'(count), 4);
    chk("fill_nshape", 32'(next_shape), 0);
    chk("fill_nvalid", 32'(next_valid), 1);
    chk("fill_mask", 32'(dut.bag_mask), 32'h70);
    rnd = 8'h04; step();
    chk("full_count", 32'(count), 4);
    chk("full_mask", 32'(dut.bag_mask), 32'h70);
    chk("full_tries", 32'(dut.tries), 0);

    // Pop from full queue
    req = 1'b1; rnd = 8'h04; step();
    chk("pop_valid", 32'(spawn_valid), 1);
    chk("pop_shape", 32'(shape), 0);
    chk("pop_rot", 32'(rot), 0);
    chk("pop_x", 32'(x), 8);
    chk("pop_y", 32'(y), 0);
    chk("pop_nshape", 32'(next_shape), 1);
    chk("pop_count", 32'(count), 3);
    req = 1'b0; rnd = 8'h0C; step();
    chk("refill_count", 32'(count), 4);
    chk("refill_valid", 32'(spawn_valid), 0);
    chk("refill_hold", 32'(shape), 0);
    chk("refill_mask", 32'(dut.bag_mask), 32'h60);
    req = 1'b1; rnd = 8'h05; step();
    chk("pop2_shape", 32'(shape), 1);
    req = 1'b0; rnd = 8'h05; step();
    chk("push5_mask", 32'(dut.bag_mask), 32'h40);
    req = 1'b1; rnd = 8'h06; step();
    chk("pop3_shape", 32'(shape), 2);
    req = 1'b0; rnd = 8'h06; step();
    chk("reload_mask", 32'(dut.bag_mask), 32'h7F);
    chk("reload_count", 32'(count), 4);
    req = 1'b1; rnd = 8'h07; step();
    chk("pop4_shape", 32'(shape), 3);
    step();
    chk("pop5_shape", 32'(shape), 4);
    chk("pop5_rot", 32'(rot), 1);
    req = 1'b0;

    // Forced accept after MAX_TRIES rejects
    rst = 1'b1; step();
    rst = 1'b0; rnd = 8'h1F;
    for (int i = 0; i < 7; i++) step();
    chk("rej_count", 32'(count), 0);
    chk("rej_tries", 32'(dut.tries), 7);
    step();
    chk("force_count", 32'(count), 1);
    chk("force_nshape", 32'(next_shape), 0);
    chk("force_tries", 32'(dut.tries), 0);
    chk("force_mask", 32'(dut.bag_mask), 32'h7E);
    req = 1'b1; step();
    req = 1'b0;
    chk("force_spawn", 32'(spawn_valid), 1);
    chk("force_shape", 32'(shape), 0);
    chk("force_rot", 32'(rot), 3);

    // 14 pops with LFSR random source
    rst = 1'b1; step();
    rst = 1'b0;
    lfsr = 8'hA5; n = 0;
    for (int c = 0; c < 500 && n < 14; c++) begin
      req = 1'b1; rnd = lfsr;
      lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      step();
      if (spawn_valid) begin
        got[n] = shape;
        n++;
      end
    end
    req = 1'b0;
    chk("perm_n", 32'(n), 14);
    seen_a = '0; seen_b = '0;
    for (int i = 0; i < 7; i++) begin
      seen_a = seen_a | (8'd1 << got[i]);
      seen_b = seen_b | (8'd1 << got[i + 7]);
    end
    chk("perm_bag1", 32'(seen_a), 32'h7F);
    chk("perm_bag2", 32'(seen_b), 32'h7F);

    // Request on empty queue
    rst = 1'b1; step();
    rst = 1'b0;
    chk("rst2_state", 32'(dut.state), 32'(ST_IDLE));
    req = 1'b1; rnd = 8'h07; step();
    chk("wait_state", 32'(dut.state), 32'(ST_WAIT));
    chk("wait_spawn", 32'(spawn_valid), 0);
    req = 1'b1; rnd = 8'h02; step();
    chk("wait_count", 32'(count), 1);
    chk("wait_spawn2", 32'(spawn_valid), 0);
    req = 1'b0; rnd = 8'h07; step();
    chk("wait_pop", 32'(spawn_valid), 1);
    chk("wait_shape", 32'(shape), 2);
    chk("wait_idle", 32'(dut.state), 32'(ST_IDLE));
    chk("wait_cnt0", 32'(count), 0);
    rnd = 8'h03; step();
    chk("nodup_spawn", 32'(spawn_valid), 0);
    chk("nodup_count", 32'(count), 1);
    rnd = 8'h04; step();
    chk("nodup_spawn2", 32'(spawn_valid), 0);
    rnd = 8'h05; step();
    chk("pre_flush_cnt", 32'(count), 3);

    // Flush with simultaneous request
    flush = 1'b1; req = 1'b1; rnd = 8'h06; step();
    flush = 1'b0; req = 1'b0;
    chk("flush_count", 32'(count), 0);
    chk("flush_spawn", 32'(spawn_valid), 0);
    chk("flush_mask", 32'(dut.bag_mask), 32'h7F);
    chk("flush_tries", 32'(dut.tries), 0);
    chk("flush_state", 32'(dut.state), 32'(ST_IDLE));
    chk("flush_shape", 32'(shape), 2);
    chk("flush_nvalid", 32'(next_valid), 0);
    rnd = 8'h05; step();
    chk("after_count", 32'(count), 1);
    chk("after_nshape", 32'(next_shape), 5);
    chk("after_mask", 32'(dut.bag_mask), 32'h5F);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
